sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 105 ++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with level and almost flags, sticky over/underflow.
// Latency: a pushed word is visible on dout one cycle after its push edge; flags follow one edge after their cause.
// Backpressure: push is refused while full unless a pop is taken that same cycle; refused pushes raise overflow.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic              flush,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [$clog2(DEPTH):0] level,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Storage is deliberately left unreset; only the pointers define what is valid.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_q;

  logic pop_acc;
  logic push_acc;
  logic flush_acc;
  logic ovf_set;
  logic unf_set;

  // Status flags come straight from the registered count so they never glitch on inputs.
  assign empty        = (level_q == '0);
  assign full         = (level_q == LW'(DEPTH));
  assign almost_empty = (level_q <= LW'(AE_LEVEL));
  assign almost_full  = (level_q >= LW'(AF_LEVEL));
  assign level        = level_q;

  // Head of queue is read combinationally; meaningless while empty.
  assign dout = mem[rd_ptr];

  // Pop is taken first so a full FIFO can still accept a push in the same cycle.
  always_comb begin
    pop_acc   = en & pop_in & ~empty;
    push_acc  = en & push_in & (~full | pop_acc);
    flush_acc = en & flush;
    ovf_set   = en & push_in & full & ~pop_acc;
    unf_set   = en & pop_in & empty;
  end

  // Write port: accepted push stores din at the write pointer; flush discards the push.
  always_ff @(posedge clk) begin
    if (push_acc && !flush_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and count bookkeeping; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush_acc) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_acc && !pop_acc) begin
        level_q <= level_q + LW'(1);
      end else if (pop_acc && !push_acc) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // Sticky error flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

endmodule
